// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// State encodings are fixed 3-bit values so the core's debug taps stay stable.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_D_ACC = 3'd1,
    ST_D_RSP = 3'd2,
    ST_I_ACC = 3'd3,
    ST_I_RSP = 3'd4
  } arb_state_e;

  localparam int MEM_LAT_DEF = 1;
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 7;

  // Latency counter must hold the value MEM_LAT itself.
  function automatic int cnt_width(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-port RAM between instruction fetch and data access.
// Data wins contention; grants alternate from the response states so fetch never starves.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_LAT    = MEM_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_ren,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic                  inst_stall,
  input  logic                  mem_ren,
  input  logic                  mem_wen,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_stall,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int              CNT_W  = cnt_width(MEM_LAT);
  localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_lat_check
    $error("mem_arbiter: MEM_LAT out of range 1..7");
  end

  arb_state_e       state;
  arb_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             data_req;
  logic             in_acc;
  logic             acc_done;
  logic             start_d;
  logic             start_i;

  assign data_req   = mem_ren | mem_wen;
  assign in_acc     = (state == ST_D_ACC) || (state == ST_I_ACC);
  assign acc_done   = (cnt == '0);
  assign mem_stall  = data_req & (state != ST_D_RSP);
  assign inst_stall = inst_ren & (state != ST_I_RSP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Each response state hands the RAM to the other side first, giving alternation.
  always_comb begin
    state_nxt = state;
    start_d   = 1'b0;
    start_i   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (data_req) begin
          start_d = 1'b1;
        end else if (inst_ren) begin
          start_i = 1'b1;
        end
      end
      ST_D_ACC: begin
        if (acc_done) begin
          state_nxt = ST_D_RSP;
        end
      end
      ST_I_ACC: begin
        if (acc_done) begin
          state_nxt = ST_I_RSP;
        end
      end
      ST_D_RSP: begin
        if (inst_ren) begin
          start_i = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_I_RSP: begin
        if (data_req) begin
          start_d = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (start_d) begin
      state_nxt = ST_D_ACC;
    end else if (start_i) begin
      state_nxt = ST_I_ACC;
    end
  end

  // RAM request registers and latency counter; a write needs no wait cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_en <= start_d | start_i;
      if (start_d) begin
        ram_we    <= mem_wen;
        ram_addr  <= mem_addr;
        ram_wdata <= mem_dout;
        cnt       <= mem_wen ? '0 : RD_CNT;
      end else if (start_i) begin
        ram_we    <= 1'b0;
        ram_addr  <= inst_addr;
        ram_wdata <= '0;
        cnt       <= RD_CNT;
      end else if (in_acc) begin
        if (!acc_done) begin
          cnt <= cnt - ONE;
        end else begin
          ram_we <= 1'b0;
        end
      end
    end
  end

  // Read data is sampled in the last access cycle and held until the next read on that side.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_data <= '0;
      mem_din   <= '0;
    end else begin
      if ((state == ST_D_ACC) && acc_done && !ram_we) begin
        mem_din <= ram_rdata;
      end
      if ((state == ST_I_ACC) && acc_done) begin
        inst_data <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, checked each cycle
// against a transaction-timeline model and a word-level memory image.
module tb_mem_arbiter;

  localparam int LAT = 1;

  logic        clk;
  logic        rst;
  logic        inst_ren;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        inst_stall;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        mem_stall;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .inst_ren(inst_ren), .inst_addr(inst_addr), .inst_data(inst_data), .inst_stall(inst_stall),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_stall(mem_stall),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    if (a == 32'h10) return 32'h2408_0005;
    if (a == 32'h200) return 32'h1234_5678;
    return (a * 32'h0100_0193) ^ 32'hC0DE_0000;
  endfunction

  // RAM environment: fixed latency, garbage on the bus whenever no read result is due.
  bit [31:0] ram_mem [256];
  bit        ram_wr  [256];
  bit        pv      [LAT];
  bit [31:0] pd      [LAT];
  bit [31:0] junk;
  logic [7:0] ram_idx;
  assign ram_idx   = ram_addr[9:2];
  assign ram_rdata = pv[LAT-1] ? pd[LAT-1] : junk;

  always @(posedge clk) begin
    junk <= junk + 32'h9E37_79B9;
    if (ram_en && ram_we) begin
      ram_mem[ram_idx] <= ram_wdata;
      ram_wr[ram_idx]  <= 1'b1;
    end
    pv[0] <= ram_en && !ram_we;
    pd[0] <= ram_wr[ram_idx] ? ram_mem[ram_idx] : init_val(ram_addr);
    for (int k = 1; k < LAT; k++) begin
      pv[k] <= pv[k-1];
      pd[k] <= pd[k-1];
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: who owns the RAM, when its strobe fires, when it answers.
  bit [31:0]   ref_mem [256];
  bit          ref_wr  [256];
  int          cyc = 0;
  int          m_side = 0;   // 0 none, 1 data, 2 fetch
  int          m_t0 = 0;
  int          m_rsp = 0;
  logic        m_we = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] exp_mem_din = '0;
  logic [31:0] exp_inst_data = '0;

  logic        s_ram_en, s_ram_we, s_mem_stall, s_inst_stall;
  logic [31:0] s_ram_addr, s_ram_wdata, s_mem_din, s_inst_data;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_wr[a[9:2]] ? ref_mem[a[9:2]] : init_val(a);
  endfunction

  task automatic start_acc(input int side);
    m_side = side;
    m_t0   = cyc + 1;
    if (side == 1) begin
      m_we    = mem_wen;
      m_addr  = mem_addr;
      m_wdata = mem_dout;
    end else begin
      m_we    = 1'b0;
      m_addr  = inst_addr;
      m_wdata = '0;
    end
    m_rsp = m_t0 + (m_we ? 1 : LAT + 1);
  endtask

  task automatic tick();
    logic dreq, in_win, rsp_d, rsp_i;
    @(negedge clk);
    s_ram_en     = ram_en;
    s_ram_we     = ram_we;
    s_ram_addr   = ram_addr;
    s_ram_wdata  = ram_wdata;
    s_mem_stall  = mem_stall;
    s_inst_stall = inst_stall;
    s_mem_din    = mem_din;
    s_inst_data  = inst_data;
    dreq   = mem_ren | mem_wen;
    in_win = (m_side != 0) && (cyc >= m_t0) && (cyc < m_rsp);
    rsp_d  = (m_side == 1) && (cyc == m_rsp);
    rsp_i  = (m_side == 2) && (cyc == m_rsp);
    if (rsp_d && !m_we) exp_mem_din = ref_rd(m_addr);
    if (rsp_i) exp_inst_data = ref_rd(m_addr);
    chk("ram_en", 32'(s_ram_en), 32'((m_side != 0) && (cyc == m_t0)));
    if (in_win) begin
      chk("ram_addr", s_ram_addr, m_addr);
      chk("ram_we", 32'(s_ram_we), 32'(m_we));
      if (m_we) chk("ram_wdata", s_ram_wdata, m_wdata);
    end
    chk("mem_stall", 32'(s_mem_stall), 32'(dreq && !rsp_d));
    chk("inst_stall", 32'(s_inst_stall), 32'(inst_ren && !rsp_i));
    chk("mem_din", s_mem_din, exp_mem_din);
    chk("inst_data", s_inst_data, exp_inst_data);
    if ((m_side == 1) && m_we && (cyc == m_t0)) begin
      ref_mem[m_addr[9:2]] = m_wdata;
      ref_wr[m_addr[9:2]]  = 1'b1;
    end
    if (rst) begin
      m_side        = 0;
      exp_mem_din   = '0;
      exp_inst_data = '0;
    end else if (m_side == 0) begin
      if (dreq) start_acc(1);
      else if (inst_ren) start_acc(2);
    end else if (cyc == m_rsp) begin
      if (m_side == 1) begin
        if (inst_ren) start_acc(2);
        else m_side = 0;
      end else begin
        if (dreq) start_acc(1);
        else m_side = 0;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input int n);
    inst_ren = 1'b0;
    mem_ren  = 1'b0;
    mem_wen  = 1'b0;
    rst      = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    bit   d_act, i_act, i_hi, ok_stall;
    int   run_d, run_i, max_d, max_i, grants;
    int   last_g, g;
    logic [31:0] a;
    rst = 1'b1; inst_ren = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
    inst_addr = '0; mem_addr = '0; mem_dout = '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) tick();
    chk("rst_ram_addr", s_ram_addr, 32'h0);
    chk("rst_ram_wdata", s_ram_wdata, 32'h0);
    chk("rst_ram_we", 32'(s_ram_we), 32'h0);
    quiet(2);

    // Lone fetch
    inst_ren = 1'b1; inst_addr = 32'h10;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 1) chk("fetch_en_c1", 32'(s_ram_en), 32'h1);
      if (k < 3) chk("fetch_stall_hi", 32'(s_inst_stall), 32'h1);
    end
    chk("fetch_stall_c3", 32'(s_inst_stall), 32'h0);
    chk("fetch_data_c3", s_inst_data, 32'h2408_0005);
    quiet(2);

    // Lone write, then read back
    mem_wen = 1'b1; mem_addr = 32'h100; mem_dout = 32'hDEAD_BEEF;
    tick();
    chk("wr_stall_c0", 32'(s_mem_stall), 32'h1);
    tick();
    chk("wr_en_we_c1", {30'd0, s_ram_en, s_ram_we}, 32'h3);
    tick();
    chk("wr_stall_c2", 32'(s_mem_stall), 32'h0);
    quiet(1);
    mem_ren = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("rd_back", s_mem_din, 32'hDEAD_BEEF);
    quiet(2);

    // Simultaneous data read and fetch
    mem_ren = 1'b1; mem_addr = 32'h200; inst_ren = 1'b1; inst_addr = 32'h14;
    i_hi = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k == 4) mem_ren = 1'b0;
      tick();
      if (k < 6) i_hi &= s_inst_stall;
      if (k == 3) begin
        chk("sim_d_stall_c3", 32'(s_mem_stall), 32'h0);
        chk("sim_d_data_c3", s_mem_din, 32'h1234_5678);
      end
      if (k == 4) chk("sim_i_en_c4", {31'd0, s_ram_en}, 32'(s_ram_addr == 32'h14));
    end
    chk("sim_i_hi_c0_5", 32'(i_hi), 32'h1);
    chk("sim_i_data_c6", s_inst_data, init_val(32'h14));
    quiet(2);

    // Continuous contention
    mem_ren = 1'b1; mem_addr = 32'h40; inst_ren = 1'b1; inst_addr = 32'h80;
    run_d = 0; run_i = 0; max_d = 0; max_i = 0; grants = 0; last_g = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      run_d = s_mem_stall ? run_d + 1 : 0;
      run_i = s_inst_stall ? run_i + 1 : 0;
      if (run_d > max_d) max_d = run_d;
      if (run_i > max_i) max_i = run_i;
      g = !s_mem_stall ? 1 : (!s_inst_stall ? 2 : 0);
      if (g != 0) begin
        if (last_g != 0) chk("alternate", g, 3 - last_g);
        last_g = g;
        grants++;
      end
    end
    ok_stall = (max_d <= 2 * (LAT + 2)) && (max_i <= 2 * (LAT + 2));
    chk("max_stall_bound", 32'(ok_stall), 32'h1);
    chk("grant_count", 32'(grants >= 4), 32'h1);
    quiet(2);

    // Reset during a read
    mem_ren = 1'b1; mem_addr = 32'h200;
    for (int k = 0; k < 7; k++) begin
      rst = (k == 2);
      tick();
      if (k == 3) begin
        chk("rst_en_c3", 32'(s_ram_en), 32'h0);
        chk("rst_din_c3", s_mem_din, 32'h0);
        chk("rst_addr_c3", s_ram_addr, 32'h0);
      end
      if (k == 4) chk("rst_restart_c4", 32'(s_ram_en), 32'h1);
    end
    chk("rst_final_data", s_mem_din, 32'h1234_5678);
    quiet(2);

    // Random traffic
    d_act = 1'b0; i_act = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      if (d_act && !s_mem_stall) d_act = 1'b0;
      if (i_act && !s_inst_stall) i_act = 1'b0;
      if (!d_act) begin
        mem_ren = 1'b0; mem_wen = 1'b0;
        if ($urandom_range(0, 2) == 0) begin
          d_act = 1'b1;
          a = $urandom_range(0, 63);
          mem_addr = a << 2;
          mem_dout = $urandom;
          mem_wen  = $urandom_range(0, 1);
          mem_ren  = mem_wen ? 1'($urandom_range(0, 1)) : 1'b1;
        end
      end
      if (!i_act) begin
        inst_ren = 1'b0;
        if ($urandom_range(0, 2) == 0) begin
          i_act = 1'b1;
          a = $urandom_range(0, 63);
          inst_addr = a << 2;
          inst_ren = 1'b1;
        end
      end
      rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    quiet(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares one single-port, fixed-latency RAM between the core's instruction-fetch port and its data-memory port.
- Sits between `mips_core` and the unified memory.
- Data accesses win contention; a pending instruction fetch is never starved.
- Each side gets a stall that is held until its access completes; the core merges the two stalls into its pipeline stall logic.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte address width (passed through untranslated)
- `DATA_WIDTH`, 32, data word width
- `MEM_LAT`, 1, cycles from `ram_en` to valid `ram_rdata` (legal range 1..7)

Ports:
- `clk`  in  1  clock; everything sampled on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `inst_ren`  in  1  fetch request
- `inst_addr`  in  ADDR_WIDTH  fetch address
- `inst_data`  out  DATA_WIDTH  fetched word; valid when `inst_ren` & !`inst_stall`
- `inst_stall`  out  1  fetch pending, not yet answered
- `mem_ren` / `mem_wen`  in  1 / 1  data read / write request
- `mem_addr`  in  ADDR_WIDTH  data address
- `mem_dout`  in  DATA_WIDTH  write data from core
- `mem_din`  out  DATA_WIDTH  read data to core; valid when `mem_ren` & !`mem_stall`
- `mem_stall`  out  1  data access pending, not yet answered
- `ram_en`  out  1  RAM access strobe, one-cycle pulse
- `ram_we`  out  1  RAM write enable
- `ram_addr`  out  ADDR_WIDTH  RAM address
- `ram_wdata`  out  DATA_WIDTH  RAM write data
- `ram_rdata`  in  DATA_WIDTH  RAM read data

## Operation
- **States:** IDLE, D_ACC, D_RSP, I_ACC, I_RSP.
- **Requests:**
  - Data request = `mem_ren`|`mem_wen`.
  - If `mem_wen` is set, the request is a write and `mem_ren` is ignored.
  - Requesters hold address/data stable while their stall is high.
- **Stalls** (combinational from registered state):
  - `mem_stall` = data request & state≠D_RSP.
  - `inst_stall` = `inst_ren` & state≠I_RSP.
- **IDLE:**
  - Data request → D_ACC.
  - Else `inst_ren` → I_ACC.
  - Else stay.
- **On entering an ACC state:**
  - Latch addr/we/wdata into the `ram_*` registers.
  - `ram_en`=1 for the first ACC cycle only.
  - `ram_addr`/`ram_we`/`ram_wdata` are held for the whole ACC state.
  - Load latency counter `cnt` (width clog2(MEM_LAT+1)).
- **ACC length:**
  - Write: 1 cycle.
  - Read: MEM_LAT+1 cycles; `ram_rdata` is captured into `mem_din`/`inst_data` in the last ACC cycle.
  - Then go to the matching RSP state.
- **RSP (exactly 1 cycle):**
  - Stall low for the granted side.
  - From D_RSP: `inst_ren` → I_ACC, else IDLE.
  - From I_RSP: data request → D_ACC, else IDLE.
  - This alternates service under continuous contention; no requester waits more than one foreign access.
- **Output registers:** `inst_data`/`mem_din` hold their last captured value until the next capture on the same side. Writes do not update `mem_din`.
- **Request withdrawn mid-access:** the RAM access still completes (no abort); the RSP cycle still occurs; the data is discarded.

## Timing
- **Reset values:** state=IDLE, `ram_en`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, `inst_data`=0, `mem_din`=0, `cnt`=0. Stalls follow their requests (low with no request).
- **Read, request at cycle 0 from IDLE:**
  - `ram_en` at cycle 1.
  - Capture at cycle 1+MEM_LAT.
  - Stall low at cycle MEM_LAT+2.
  - With MEM_LAT=1: 3-cycle access, stall high in cycles 0–2.
- **Write, request at cycle 0 from IDLE:**
  - `ram_en`=`ram_we`=1 at cycle 1.
  - Stall low at cycle 2.
- **Simultaneous data+fetch in IDLE:** data is served first; the fetch follows immediately from D_RSP with no IDLE bubble.
- **Reset mid-operation:**
  - Next cycle is IDLE with all outputs at reset values.
  - The in-flight RAM read result is ignored.
  - Any `ram_we` is dropped at the reset edge.
- **Back-to-back same-side requests** pass through IDLE, costing one bubble cycle.

## Structure
- State encodings (3-bit localparams) and the `MEM_LAT` default belong in `define.vh` alongside the existing core constants.
- Single flat module; the latency counter is too small to justify a sub-module.
- Instantiated next to `mips_core` in the top level.
  - The core's `inst_*`/`mem_*` ports connect directly.
  - Stall outputs feed the core's stall logic.

## Test plan
- **Lone fetch**, MEM_LAT=1, `inst_addr`=0x0000_0010, RAM[0x10]=0x2408_0005 → `ram_en` at cycle 1, `inst_stall` high cycles 0–2, `inst_data`=0x2408_0005 with stall low at cycle 3.
- **Lone write** `mem_addr`=0x0000_0100, `mem_dout`=0xDEAD_BEEF → `ram_en`=`ram_we`=1 at cycle 1, `mem_stall` low at cycle 2; a following read of 0x100 returns 0xDEAD_BEEF.
- **Simultaneous** `mem_ren`@0x200 (=0x1234_5678) and `inst_ren`@0x14 → data answered at cycle 3, I_ACC entered at cycle 4, fetch answered at cycle 6. `inst_stall` stays high throughout cycles 0–5.
- **Continuous contention** for 20 cycles → grants alternate D,I,D,I; neither stall is high longer than 2·(MEM_LAT+2) cycles.
- **MEM_LAT=3 read** → capture at cycle 4, stall low at cycle 5; `ram_addr` stable during cycles 1–4.
- **`rst` asserted at cycle 2 of a read** → cycle 3: state IDLE, `ram_en`=0, `mem_din`=0. With the request still held, a new access starts with `ram_en` at cycle 4.
